// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined saturating ALU: opcode map, opcode width
// and the default Q-format used by the fixed-point multiply.
package alu_pipe_pkg;

    localparam int ALU_OPW      = 8;
    localparam int ALU_DEF_N    = 16;
    localparam int ALU_DEF_FRAC = 12;
    localparam int ALU_DEF_SW   = 5;

    localparam logic [ALU_OPW-1:0] ALU_NOP  = 8'h00;
    localparam logic [ALU_OPW-1:0] ALU_ADD  = 8'h01;
    localparam logic [ALU_OPW-1:0] ALU_SUB  = 8'h02;
    localparam logic [ALU_OPW-1:0] ALU_MUL  = 8'h03;
    localparam logic [ALU_OPW-1:0] ALU_AND  = 8'h04;
    localparam logic [ALU_OPW-1:0] ALU_OR   = 8'h05;
    localparam logic [ALU_OPW-1:0] ALU_XOR  = 8'h06;
    localparam logic [ALU_OPW-1:0] ALU_SHLA = 8'h07;
    localparam logic [ALU_OPW-1:0] ALU_SHRA = 8'h08;
    localparam logic [ALU_OPW-1:0] ALU_SHRL = 8'h09;
    localparam logic [ALU_OPW-1:0] ALU_ROL  = 8'h0A;
    localparam logic [ALU_OPW-1:0] ALU_ROR  = 8'h0B;

endpackage

// File: rtl/alu_sat.sv
// Signed narrowing from W to N bits: passes the value through when it fits,
// otherwise clamps to the nearest N-bit extreme and raises sat.
module alu_sat #(
    parameter int W = 33,
    parameter int N = 16
) (
    input  logic signed [W-1:0] x,
    output logic        [N-1:0] y,
    output logic                sat
);

    logic fits;

    // The value fits when every bit from the new sign position upward matches x's sign.
    assign fits = (x[W-1:N-1] == {(W-N+1){x[W-1]}});
    assign sat  = !fits;
    assign y    = fits     ? x[N-1:0]
                : x[W-1]   ? {1'b1, {(N-1){1'b0}}}
                :            {1'b0, {(N-1){1'b1}}};

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: stage 1 captures the operation, stage 2 computes
// and registers a saturated result with status flags.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int N    = ALU_DEF_N,
    parameter int FRAC = ALU_DEF_FRAC,
    parameter int SW   = ALU_DEF_SW,
    parameter int OPW  = ALU_OPW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] opcode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [SW-1:0]  shift,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   y,
    output logic           sat,
    output logic           zero,
    output logic           neg,
    output logic           err
);

    localparam int WA = N + 2**SW + 1;
    localparam int WM = 2 * N;
    localparam int WS = (WA > WM) ? WA : WM;

    logic                 adv1, adv2;
    logic                 s1_valid;
    logic [OPW-1:0]       s1_op;
    logic signed [N-1:0]  s1_a, s1_b;
    logic [SW-1:0]        s1_shift;

    logic signed [WS-1:0] a_shl, b_ext, sum, diff, sat_in;
    logic signed [WM-1:0] prod, prod_q;
    logic [N-1:0]         sat_y;
    logic                 sat_flag;
    logic [2*N-1:0]       dbl;
    int                   rot;
    logic [N-1:0]         y_next;
    logic                 sat_next, err_next;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)       s1_valid <= 1'b0;
        else if (adv1) s1_valid <= in_valid;
    end

    // NOTE: operand registers carry no reset; s1_valid alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            s1_op    <= opcode;
            s1_a     <= a;
            s1_b     <= b;
            s1_shift <= shift;
        end
    end

    // ADD/SUB work in a width that holds the largest pre-shifted operand without loss.
    assign a_shl  = WS'(s1_a) <<< s1_shift;
    assign b_ext  = WS'(s1_b);
    assign sum    = a_shl + b_ext;
    assign diff   = b_ext - a_shl;
    assign prod   = WM'(s1_a) * WM'(s1_b);
    assign prod_q = prod >>> FRAC;

    always_comb begin
        sat_in = sum;
        if (s1_op == ALU_SUB)      sat_in = diff;
        else if (s1_op == ALU_MUL) sat_in = WS'(prod_q);
    end

    alu_sat #(.W(WS), .N(N)) u_sat (
        .x   (sat_in),
        .y   (sat_y),
        .sat (sat_flag)
    );

    assign rot = int'(s1_shift) % N;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        y_next   = '0;
        sat_next = 1'b0;
        err_next = 1'b0;
        dbl      = '0;
        case (s1_op)
            ALU_NOP: y_next = '0;
            ALU_ADD, ALU_SUB, ALU_MUL: begin
                y_next   = sat_y;
                sat_next = sat_flag;
            end
            ALU_AND: y_next = s1_a & s1_b;
            ALU_OR:  y_next = s1_a | s1_b;
            ALU_XOR: y_next = s1_a ^ s1_b;
            ALU_SHLA: begin
                if (int'(s1_shift) >= N) y_next = '0;
                else                     y_next = s1_a << s1_shift;
            end
            ALU_SHRA: begin
                if (int'(s1_shift) >= N) y_next = {N{s1_a[N-1]}};
                else                     y_next = s1_a >>> s1_shift;
            end
            ALU_SHRL: begin
                if (int'(s1_shift) >= N) y_next = '0;
                else                     y_next = s1_b >> s1_shift;
            end
            ALU_ROL: begin
                dbl    = {s1_a, s1_a} << rot;
                y_next = dbl[2*N-1:N];
            end
            ALU_ROR: begin
                dbl    = {s1_a, s1_a} >> rot;
                y_next = dbl[N-1:0];
            end
            default: err_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            sat       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            err       <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y    <= y_next;
                sat  <= sat_next;
                zero <= (y_next == '0);
                neg  <= y_next[N-1];
                err  <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases, randomized traffic
// with back-pressure, and mid-flight reset, against an arithmetic reference model.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  opcode;
    logic [15:0] a, b;
    logic [4:0]  shift;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        sat, zero, neg, err;

    typedef struct {
        logic [15:0] y;
        logic        sat;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pop    = 0;
    logic        rst_d    = 1'b0;
    logic        stall    = 1'b0;
    logic [15:0] snap_y;
    logic [3:0]  snap_f;

    alu_pipe #(.N(16), .FRAC(12), .SW(5), .OPW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sat       (sat),
        .zero      (zero),
        .neg       (neg),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t clamp(input longint v);
        exp_t e;
        e.err = 1'b0;
        if (v > 32767)       begin e.y = 16'h7FFF; e.sat = 1'b1; end
        else if (v < -32768) begin e.y = 16'h8000; e.sat = 1'b1; end
        else                 begin e.y = v[15:0];  e.sat = 1'b0; end
        return e;
    endfunction

    // Reference: plain 64-bit integer arithmetic straight from the operation definitions.
    function automatic exp_t model(input logic [7:0] op, input logic [15:0] av_in,
                                   input logic [15:0] bv_in, input logic [4:0] sh);
        exp_t        e;
        longint      av, bv, v;
        int unsigned au, bu, r;
        av = longint'($signed(av_in));
        bv = longint'($signed(bv_in));
        au = {16'h0, av_in};
        bu = {16'h0, bv_in};
        r  = {27'h0, sh} % 16;
        e.y = 16'h0; e.sat = 1'b0; e.err = 1'b0;
        case (op)
            ALU_NOP:  e.y = 16'h0;
            ALU_ADD:  e = clamp(av * (longint'(1) << sh) + bv);
            ALU_SUB:  e = clamp(bv - av * (longint'(1) << sh));
            ALU_MUL:  e = clamp((av * bv) >>> 12);
            ALU_AND:  e.y = av_in & bv_in;
            ALU_OR:   e.y = av_in | bv_in;
            ALU_XOR:  e.y = av_in ^ bv_in;
            ALU_SHLA: begin v = av << sh; e.y = (sh >= 16) ? 16'h0 : v[15:0]; end
            ALU_SHRA: begin v = av >>> sh; e.y = (sh >= 16) ? {16{av_in[15]}} : v[15:0]; end
            ALU_SHRL: begin v = longint'(bu >> sh); e.y = (sh >= 16) ? 16'h0 : v[15:0]; end
            ALU_ROL:  begin v = longint'(((au << r) | (au >> (16 - r))) & 32'hFFFF); e.y = v[15:0]; end
            ALU_ROR:  begin v = longint'(((au >> r) | (au << (16 - r))) & 32'hFFFF); e.y = v[15:0]; end
            default:  e.err = 1'b1;
        endcase
        return e;
    endfunction

    always @(posedge clk) rst_d <= rst;

    // Monitor: 2-deep in-order queue model, stall stability, reset clearing.
    always @(negedge clk) begin
        exp_t e;
        if (rst_d) begin
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_y",         64'(y),         64'(0));
            check("rst_flags",     64'({sat, zero, neg, err}), 64'(0));
        end
        if (rst) begin
            q.delete();
            stall = 1'b0;
        end else begin
            if (stall && !rst_d) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_y",     64'(y),         64'(snap_y));
                check("stall_flags", 64'({sat, zero, neg, err}), 64'(snap_f));
            end
            check("in_ready", 64'(in_ready), 64'(!(q.size() >= 2 && !out_ready)));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 64'(q.size()), 64'(1));
                end else begin
                    e = q.pop_front();
                    n_pop++;
                    check("out_y",    64'(y),    64'(e.y));
                    check("out_sat",  64'(sat),  64'(e.sat));
                    check("out_err",  64'(err),  64'(e.err));
                    check("out_zero", 64'(zero), 64'(e.y == 16'h0));
                    check("out_neg",  64'(neg),  64'(e.y[15]));
                end
            end
            if (in_valid && in_ready) q.push_back(model(opcode, a, b, shift));
            stall  = out_valid && !out_ready;
            snap_y = y;
            snap_f = {sat, zero, neg, err};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && g < 50) begin
            tick();
            g++;
        end
        check("drain_empty", 64'(q.size()), 64'(0));
    endtask

    // Issue one operation into an empty pipeline and check latency and result directly.
    task automatic single(input string tag, input logic [7:0] op, input logic [15:0] av_in,
                          input logic [15:0] bv_in, input logic [4:0] sh,
                          input logic [15:0] ey, input logic esat, input logic eerr);
        int lat;
        opcode = op; a = av_in; b = bv_in; shift = sh;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        check({tag, "_lat"},  64'(lat),  64'(2));
        check({tag, "_y"},    64'(y),    64'(ey));
        check({tag, "_sat"},  64'(sat),  64'(esat));
        check({tag, "_err"},  64'(err),  64'(eerr));
        check({tag, "_zero"}, 64'(zero), 64'(ey == 16'h0));
        check({tag, "_neg"},  64'(neg),  64'(ey[15]));
        tick();
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            4:       return 16'($urandom_range(0, 8191));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [7:0] ops [12];
        bit         pat [4];
        int         cyc, sent, guard, pop0;
        logic       acc;
        ops = '{ALU_NOP, ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR,
                ALU_XOR, ALU_SHLA, ALU_SHRA, ALU_SHRL, ALU_ROL, ALU_ROR};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = 8'h0; a = 16'h0; b = 16'h0; shift = 5'd0;
        repeat (3) tick();
        check("reset_out_valid", 64'(out_valid), 64'(0));
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", 64'(in_ready), 64'(1));

        single("add_sat",   ALU_ADD,  16'h7000, 16'h2000, 5'd0,  16'h7FFF, 1'b1, 1'b0);
        single("sub_sat",   ALU_SUB,  16'h4000, 16'h8000, 5'd1,  16'h8000, 1'b1, 1'b0);
        single("add_zero",  ALU_ADD,  16'h0001, 16'hFFFF, 5'd0,  16'h0000, 1'b0, 1'b0);
        single("mul_one",   ALU_MUL,  16'h1000, 16'h1000, 5'd0,  16'h1000, 1'b0, 1'b0);
        single("mul_sat",   ALU_MUL,  16'h7FFF, 16'h7FFF, 5'd0,  16'h7FFF, 1'b1, 1'b0);
        single("mul_neg",   ALU_MUL,  16'hF000, 16'h1000, 5'd0,  16'hF000, 1'b0, 1'b0);
        single("rol4",      ALU_ROL,  16'h1234, 16'h0000, 5'd4,  16'h2341, 1'b0, 1'b0);
        single("rol20",     ALU_ROL,  16'h1234, 16'h0000, 5'd20, 16'h2341, 1'b0, 1'b0);
        single("rol16",     ALU_ROL,  16'h1234, 16'h0000, 5'd16, 16'h1234, 1'b0, 1'b0);
        single("ror4",      ALU_ROR,  16'h1234, 16'h0000, 5'd4,  16'h4123, 1'b0, 1'b0);
        single("shra31",    ALU_SHRA, 16'h8000, 16'h0000, 5'd31, 16'hFFFF, 1'b0, 1'b0);
        single("shla16",    ALU_SHLA, 16'h1234, 16'h0000, 5'd16, 16'h0000, 1'b0, 1'b0);
        single("illegal",   8'hEE,    16'h1234, 16'h5678, 5'd3,  16'h0000, 1'b0, 1'b1);
        single("nop",       ALU_NOP,  16'h1234, 16'h5678, 5'd0,  16'h0000, 1'b0, 1'b0);

        // Randomized traffic with random valid and back-pressure.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            opcode    = ($urandom_range(0, 12) == 12) ? 8'($urandom_range(12, 255))
                                                      : ops[$urandom_range(0, 11)];
            a         = pick();
            b         = pick();
            shift     = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Eight back-to-back ADDs under a 1,0,0,1 out_ready pattern.
        pop0 = n_pop; cyc = 0; sent = 0; guard = 0;
        while (sent < 8 && guard < 200) begin
            opcode = ALU_ADD; a = 16'(16'h0400 * sent + 16'h0011);
            b = 16'($urandom); shift = 5'(sent % 3);
            in_valid = 1'b1; out_ready = pat[cyc % 4];
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++; guard++;
            if (acc) sent++;
        end
        check("bp_issued", 64'(sent), 64'(8));
        in_valid = 1'b0;
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            out_ready = pat[cyc % 4];
            tick();
            cyc++; guard++;
        end
        drain();
        check("bp_popped", 64'(n_pop - pop0), 64'(8));

        // Reset with two operations in flight.
        out_ready = 1'b1; opcode = ALU_ADD; shift = 5'd0;
        a = 16'h0101; b = 16'h0001; in_valid = 1'b1;
        tick();
        a = 16'h0202;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        check("rst_mid_out_valid", 64'(out_valid), 64'(0));
        check("rst_mid_y",         64'(y),         64'(0));
        rst = 1'b0;
        repeat (4) begin
            tick();
            check("flushed_quiet", 64'(out_valid), 64'(0));
        end
        single("post_rst", ALU_ADD, 16'h0010, 16'h0020, 5'd0, 16'h0030, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
